// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Command-side initiator for the ALU. Parses UART-RX frames
//   (0xCC,A,B,FUN = load operands and execute; 0xDD,FUN = execute with the
//   stored operands), issues a one-cycle ALU_EN, waits for OUT_VALID, then
//   writes the 16-bit result to the TX FIFO, low byte first. The ALU clock
//   is enabled only while an operation is issued or in flight.
//
//   Optional feature macro: ALU_CMD_TIMEOUT_EN
//     When defined, a watchdog aborts WAIT_RES after TIMEOUT cycles without
//     OUT_VALID and pulses ERR. When undefined, ERR is tied low.
//
// Ports
//   CLK, RST          : clock (rising edge), async active-high reset
//   RX_P_DATA/RX_D_VLD: received byte and its one-cycle strobe
//   ALU_OUT/OUT_VALID : ALU result and its valid strobe
//   FIFO_FULL         : TX FIFO cannot accept a write
//   ALU_A/ALU_B       : operand registers
//   ALU_FUN           : function code ([3:2] = class)
//   ALU_EN            : one-cycle operation request
//   CLK_GATE_EN       : ALU clock enable
//   TX_P_DATA/TX_D_VLD: FIFO write data / write strobe
//   CMD_DROP          : a byte received while busy was discarded
//   ERR               : watchdog abort pulse
module alu_cmd_issuer #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  RX_P_DATA,
   input  logic        RX_D_VLD,
   input  logic [15:0] ALU_OUT,
   input  logic        OUT_VALID,
   input  logic        FIFO_FULL,
   output logic [7:0]  ALU_A,
   output logic [7:0]  ALU_B,
   output logic [3:0]  ALU_FUN,
   output logic        ALU_EN,
   output logic        CLK_GATE_EN,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_D_VLD,
   output logic        CMD_DROP,
   output logic        ERR
);

   typedef enum logic [2:0] {
      IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI
   } state_t;

   state_t      state, next_state;
   logic [15:0] result;
   logic        timeout_hit;
   logic        busy;
   logic        alu_en_d, gate_d, tx_vld_d, drop_d;
   logic [7:0]  tx_data_d;

`ifdef ALU_CMD_TIMEOUT_EN
   localparam int unsigned CW_MIN = $clog2(TIMEOUT + 1);
   localparam int unsigned CW     = (CW_MIN > 8) ? CW_MIN : 8;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] wd_cnt;

   // Held at zero outside WAIT_RES, so it starts from zero on every entry.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         wd_cnt <= '0;
      else if (state == WAIT_RES)
         wd_cnt <= wd_cnt + 1'b1;
      else
         wd_cnt <= '0;
   end

   // A result arriving in the last cycle still wins over the abort.
   always_comb timeout_hit = (state == WAIT_RES) && !OUT_VALID && (wd_cnt == LAST);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         ERR <= 1'b0;
      else
         ERR <= timeout_hit;
   end
`else
   always_comb timeout_hit = 1'b0;
   assign ERR = 1'b0;

   // TIMEOUT only matters to the watchdog build.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (RX_D_VLD && RX_P_DATA == 8'hCC)
               next_state = GET_A;
            else if (RX_D_VLD && RX_P_DATA == 8'hDD)
               next_state = GET_FUN;
         end
         GET_A:    if (RX_D_VLD) next_state = GET_B;
         GET_B:    if (RX_D_VLD) next_state = GET_FUN;
         GET_FUN:  if (RX_D_VLD) next_state = ISSUE;
         ISSUE:    next_state = WAIT_RES;
         WAIT_RES: begin
            if (OUT_VALID)
               next_state = SEND_LO;
            else if (timeout_hit)
               next_state = IDLE;
         end
         SEND_LO:  if (!FIFO_FULL) next_state = SEND_HI;
         SEND_HI:  if (!FIFO_FULL) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs. ALU_EN and
   // CLK_GATE_EN are derived from next_state so the registered copies line
   // up with the cycles spent in ISSUE / WAIT_RES.
   always_comb begin
      busy      = (state == ISSUE) || (state == WAIT_RES) ||
                  (state == SEND_LO) || (state == SEND_HI);
      alu_en_d  = (next_state == ISSUE);
      gate_d    = (next_state == ISSUE) || (next_state == WAIT_RES);
      tx_vld_d  = ((state == SEND_LO) || (state == SEND_HI)) && !FIFO_FULL;
      tx_data_d = (state == SEND_HI) ? result[15:8] : result[7:0];
      drop_d    = busy && RX_D_VLD;
   end

   // Output and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ALU_A       <= '0;
         ALU_B       <= '0;
         ALU_FUN     <= '0;
         ALU_EN      <= 1'b0;
         CLK_GATE_EN <= 1'b0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
         CMD_DROP    <= 1'b0;
         result      <= '0;
      end else begin
         ALU_EN      <= alu_en_d;
         CLK_GATE_EN <= gate_d;
         TX_D_VLD    <= tx_vld_d;
         CMD_DROP    <= drop_d;
         if (tx_vld_d)
            TX_P_DATA <= tx_data_d;
         if (RX_D_VLD) begin
            case (state)
               GET_A:   ALU_A   <= RX_P_DATA;
               GET_B:   ALU_B   <= RX_P_DATA;
               GET_FUN: ALU_FUN <= RX_P_DATA[3:0];
               default: ;
            endcase
         end
         if (state == WAIT_RES && OUT_VALID)
            result <= ALU_OUT;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_P_DATA = 8'h00;
   logic        RX_D_VLD = 1'b0;
   logic [15:0] ALU_OUT = 16'h0000;
   logic        OUT_VALID = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_DROP, ERR;

   alu_cmd_issuer #(.TIMEOUT(32)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
      .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .CMD_DROP(CMD_DROP), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference ALU behaviour used by the ALU stand-in and the random model.
   function automatic logic [15:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] f);
      case (f)
         4'd0:  return {8'h00, a} + {8'h00, b};
         4'd1:  return {8'h00, a} - {8'h00, b};
         4'd2:  return {8'h00, a} * {8'h00, b};
         4'd3:  return {8'h00, a};
         4'd4:  return {8'h00, a & b};
         4'd5:  return {8'h00, a | b};
         4'd6:  return {8'h00, a ^ b};
         4'd7:  return {8'h00, ~a};
         4'd8:  return {15'h0000, a == b};
         4'd9:  return {15'h0000, a > b};
         4'd10: return {15'h0000, a < b};
         4'd12: return {8'h00, a} << 1;
         4'd13: return {8'h00, a >> 1};
         4'd14: return {8'h00, b} << 1;
         4'd15: return {8'h00, b >> 1};
         default: return 16'h0000;
      endcase
   endfunction

   // Monitor: record FIFO writes and count pulses.
   logic [7:0]  tx_q[$];
   int unsigned tx_cyc[$];
   int          drop_cnt = 0, en_cnt = 0, err_cnt = 0;
   int unsigned en_cyc = 0, err_cyc = 0;

   always @(negedge CLK) begin
      if (TX_D_VLD === 1'b1) begin
         tx_q.push_back(TX_P_DATA);
         tx_cyc.push_back(cyc);
      end
      if (CMD_DROP === 1'b1) drop_cnt++;
      if (ALU_EN === 1'b1) begin en_cnt++; en_cyc = cyc; end
      if (ERR === 1'b1) begin err_cnt++; err_cyc = cyc; end
   end

   // ALU stand-in: answers 'lat' cycles after seeing ALU_EN.
   int          lat = 1;
   bit          alu_mute = 1'b0;
   bit          force_en = 1'b0;
   logic [15:0] force_val = 16'h0000;
   int          cd = 0;

   always @(negedge CLK) begin
      OUT_VALID = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            OUT_VALID = 1'b1;
            ALU_OUT = force_en ? force_val : model_alu(ALU_A, ALU_B, ALU_FUN);
         end
      end
      if (ALU_EN === 1'b1 && !alu_mute) cd = lat;
   end

   function automatic logic [7:0] get_tx(input int i);
      if (i < tx_q.size()) return tx_q[i];
      return 8'hxx;
   endfunction

   int gap_max = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick($urandom_range(0, gap_max));
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   // Sends a frame; returns at mid-cycle one cycle after ISSUE.
   task automatic run_frame(input bit short_f, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] fun, input bit inject);
      if (short_f) send_byte(8'hDD);
      else begin
         send_byte(8'hCC);
         send_byte(a);
         send_byte(b);
      end
      send_byte(fun);
      chk("alu_en_in_issue", ALU_EN, 1);
      chk("gate_in_issue", CLK_GATE_EN, 1);
      if (inject) begin
         RX_P_DATA = 8'h77;
         RX_D_VLD  = 1'b1;
      end
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      chk("alu_en_single", ALU_EN, 0);
   endtask

   task automatic wait_tx(input int target, input int budget, input bit rnd);
      int n = 0;
      while (tx_q.size() < target && n < budget) begin
         @(negedge CLK);
         if (rnd) FIFO_FULL = ($urandom_range(0, 2) == 0);
         n++;
      end
      FIFO_FULL = 1'b0;
      chk("tx_wait_budget", tx_q.size() >= target, 1);
   endtask

   typedef struct {
      bit          short_f;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  fun;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d checks expected completion", n_total);
      $fatal(1);
   end

   initial begin
      int tx0, d0, e0, k;
      logic [7:0] ra, rb, rf, junk;
      bit sh, inj;
      logic [15:0] ex;

      // short frames list the operands they expect to reuse
      tbl[0] = '{1'b0, 8'h05, 8'h03, 8'h00, 16'h0008};
      tbl[1] = '{1'b1, 8'h05, 8'h03, 8'h0C, 16'h000A};
      tbl[2] = '{1'b0, 8'hF0, 8'h10, 8'h01, 16'h00E0};
      tbl[3] = '{1'b0, 8'h10, 8'h20, 8'h22, 16'h0200};
      tbl[4] = '{1'b1, 8'h10, 8'h20, 8'h06, 16'h0030};
      tbl[5] = '{1'b0, 8'hFF, 8'hFF, 8'h08, 16'h0001};
      tbl[6] = '{1'b1, 8'hFF, 8'hFF, 8'h99, 16'h0000};
      tbl[7] = '{1'b0, 8'h81, 8'h02, 8'hFE, 16'h0004};
      tbl[8] = '{1'b0, 8'h80, 8'h00, 8'h0C, 16'h0100};
      tbl[9] = '{1'b0, 8'h00, 8'h01, 8'h01, 16'hFFFF};

      // ---- reset state ----
      tick(3);
      chk("rst_alu_a", ALU_A, 0);
      chk("rst_alu_fun", ALU_FUN, 0);
      chk("rst_gate", CLK_GATE_EN, 0);
      RST = 1'b0;
      tick(2);
      chk("idle_alu_b", ALU_B, 0);
      chk("idle_alu_en", ALU_EN, 0);
      chk("idle_tx", {TX_P_DATA, TX_D_VLD, CMD_DROP, ERR}, 0);

      // ---- table vectors ----
      for (int i = 0; i < 10; i++) begin
         tx0 = tx_q.size();
         e0  = en_cnt;
         run_frame(tbl[i].short_f, tbl[i].a, tbl[i].b, tbl[i].fun, 1'b0);
         wait_tx(tx0 + 2, 50, 1'b0);
         chk($sformatf("tbl%0d_lo", i), get_tx(tx0), tbl[i].exp[7:0]);
         chk($sformatf("tbl%0d_hi", i), get_tx(tx0 + 1), tbl[i].exp[15:8]);
         chk($sformatf("tbl%0d_a", i), ALU_A, tbl[i].a);
         chk($sformatf("tbl%0d_b", i), ALU_B, tbl[i].b);
         chk($sformatf("tbl%0d_fun", i), ALU_FUN, tbl[i].fun[3:0]);
         chk($sformatf("tbl%0d_en_cnt", i), en_cnt - e0, 1);
      end

      // ---- FIFO backpressure ----
      force_en  = 1'b1;
      force_val = 16'h1234;
      FIFO_FULL = 1'b1;
      tx0 = tx_q.size();
      send_byte(8'hDD);
      send_byte(8'h00);
      k = 0;
      while (OUT_VALID !== 1'b1 && k < 20) begin @(negedge CLK); #1; k++; end
      chk("bp_out_valid_seen", OUT_VALID, 1);
      tick(6);
      chk("bp_no_write_stall", tx_q.size(), tx0);
      chk("bp_gate_off", CLK_GATE_EN, 0);
      FIFO_FULL = 1'b0;
      wait_tx(tx0 + 2, 20, 1'b0);
      chk("bp_lo", get_tx(tx0), 8'h34);
      chk("bp_hi", get_tx(tx0 + 1), 8'h12);
      chk("bp_consecutive", (tx_q.size() >= tx0 + 2) ? tx_cyc[tx0 + 1] - tx_cyc[tx0] : 0, 1);
      force_en = 1'b0;

      // ---- junk in IDLE, byte during WAIT_RES (operands now 0x00/0x01) ----
      lat = 6;
      d0 = drop_cnt;
      send_byte(8'h55);
      tick(2);
      chk("junk_no_drop", drop_cnt - d0, 0);
      tx0 = tx_q.size();
      send_byte(8'hDD);
      send_byte(8'h0E);
      tick(2);
      RX_P_DATA = 8'h77;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      wait_tx(tx0 + 2, 40, 1'b0);
      chk("wait_drop_once", drop_cnt - d0, 1);
      chk("wait_drop_lo", get_tx(tx0), 8'h02);
      chk("wait_drop_hi", get_tx(tx0 + 1), 8'h00);

      // ---- OUT_VALID and RX strobe in the same WAIT_RES cycle ----
      lat = 3;
      d0 = drop_cnt;
      tx0 = tx_q.size();
      send_byte(8'hDD);
      send_byte(8'h05);
      k = 0;
      while (OUT_VALID !== 1'b1 && k < 20) begin @(negedge CLK); #1; k++; end
      RX_P_DATA = 8'h44;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      wait_tx(tx0 + 2, 40, 1'b0);
      chk("same_cyc_drop", drop_cnt - d0, 1);
      chk("same_cyc_lo", get_tx(tx0), 8'h01);
      chk("same_cyc_hi", get_tx(tx0 + 1), 8'h00);

      // ---- reset mid-frame ----
      lat = 1;
      send_byte(8'hCC);
      send_byte(8'h05);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("midrst_a", ALU_A, 0);
      chk("midrst_b", ALU_B, 0);
      chk("midrst_fun", ALU_FUN, 0);
      chk("midrst_tx_data", TX_P_DATA, 0);
      chk("midrst_flags", {ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_DROP, ERR}, 0);
      @(negedge CLK);
      RST = 1'b0;
      d0 = drop_cnt;
      send_byte(8'h03);
      tick(2);
      chk("post_rst_a", ALU_A, 0);
      chk("post_rst_b", ALU_B, 0);
      chk("post_rst_no_drop", drop_cnt - d0, 0);
      tx0 = tx_q.size();
      run_frame(1'b1, 8'h00, 8'h00, 8'h07, 1'b0);
      wait_tx(tx0 + 2, 40, 1'b0);
      chk("post_rst_lo", get_tx(tx0), 8'hFF);
      chk("post_rst_hi", get_tx(tx0 + 1), 8'h00);

`ifdef ALU_CMD_TIMEOUT_EN
      // ---- watchdog ----
      alu_mute = 1'b1;
      tx0 = tx_q.size();
      e0  = err_cnt;
      send_byte(8'hDD);
      send_byte(8'h00);
      k = 0;
      while (err_cnt == e0 && k < 80) begin @(negedge CLK); k++; end
      tick(4);
      chk("wd_err_once", err_cnt - e0, 1);
      chk("wd_err_cycle", err_cyc - en_cyc, 33);
      chk("wd_no_write", tx_q.size(), tx0);
      chk("wd_gate_off", CLK_GATE_EN, 0);
      alu_mute = 1'b0;
`endif

      // ---- randomized frames against the reference model ----
      ra = 8'h00;
      rb = 8'h00;
      gap_max = 3;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            junk = 8'($urandom);
            if (junk == 8'hCC || junk == 8'hDD) junk = 8'h5A;
            send_byte(junk);
         end
         sh = ($urandom_range(0, 2) == 0);
         if (!sh) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
         end
         rf  = 8'($urandom);
         lat = $urandom_range(1, 4);
         inj = 1'($urandom_range(0, 1));
         ex  = model_alu(ra, rb, rf[3:0]);
         tx0 = tx_q.size();
         d0  = drop_cnt;
         run_frame(sh, ra, rb, rf, inj);
         wait_tx(tx0 + 2, 200, 1'b1);
         chk($sformatf("rnd%0d_lo", it), get_tx(tx0), ex[7:0]);
         chk($sformatf("rnd%0d_hi", it), get_tx(tx0 + 1), ex[15:8]);
         chk($sformatf("rnd%0d_drop", it), drop_cnt - d0, inj);
         chk($sformatf("rnd%0d_a", it), ALU_A, ra);
         chk($sformatf("rnd%0d_b", it), ALU_B, rb);
      end

`ifndef ALU_CMD_TIMEOUT_EN
      chk("err_never", err_cnt, 0);
`endif

      tick(3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
